// File: rtl/fifo_rr_wr_arbiter_pkg.sv
// Shared types and constants for the round-robin FIFO write arbiter.
// The round-robin picker wraps by binary overflow, so NCH must stay a power of two.
package fifo_rr_wr_arbiter_pkg;

    localparam int NCH         = 4;
    localparam int DW          = 8;
    localparam int FIFO_DEPTH  = 64;
    localparam int FIFO_THRESH = 32;
    localparam int IDX_W       = $clog2(NCH);
    localparam int CNT_W       = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef logic [IDX_W-1:0] ch_idx_t;

endpackage

// File: rtl/fifo_rr_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of elig_i after pivot_i, with wrap.
module fifo_rr_wr_arbiter_rr_pick
    import fifo_rr_wr_arbiter_pkg::*;
(
    input  logic [NCH-1:0] elig_i,
    input  ch_idx_t        pivot_i,
    output ch_idx_t        idx_o,
    output logic           valid_o
);

    ch_idx_t cand;

    // Scan from the farthest offset down so the nearest candidate after the pivot wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = NCH; k >= 1; k--) begin
            cand = pivot_i + IDX_W'(k);
            if (elig_i[cand]) begin
                idx_o   = cand;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin write arbiter: four producers share one FIFO write port in bounded bursts,
// with low-priority channels held off while the FIFO is at or above half full.
module fifo_rr_wr_arbiter
    import fifo_rr_wr_arbiter_pkg::*;
#(
    parameter int             MAX_BURST  = 8,
    parameter logic [NCH-1:0] HIPRI_MASK = 4'b0001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*DW-1:0] req_data,
    input  logic [NCH-1:0]    req_last,
    output logic [NCH-1:0]    gnt,
    output logic              fifo_wr_en,
    output logic [DW-1:0]     fifo_buf_in,
    input  logic              fifo_buf_full,
    input  logic              fifo_threshold,
    input  logic              fifo_overflow,
    output logic [IDX_W-1:0]  owner,
    output logic              busy,
    output logic              err_ovf
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_e             state_q, state_d;
    ch_idx_t            owner_q, owner_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               busy_q;
    logic               err_ovf_q;

    logic [NCH-1:0]     elig;
    ch_idx_t            pick_idx;
    logic               pick_valid;
    logic               beat_ok;

    assign elig = fifo_threshold ? (req & HIPRI_MASK) : req;

    fifo_rr_wr_arbiter_rr_pick u_pick (
        .elig_i  (elig),
        .pivot_i (owner_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Reset gating keeps a burst that is being aborted from writing in the reset cycle.
    assign beat_ok     = (state_q == BURST) && req[owner_q] && !fifo_buf_full && !rst;
    assign fifo_wr_en  = beat_ok;
    assign fifo_buf_in = beat_ok ? req_data[owner_q*DW +: DW] : '0;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_gnt
            assign gnt[gi] = beat_ok && (owner_q == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d    = BURST;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                end else if (beat_ok) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (req_last[owner_q] || (beat_cnt_q == LAST_BEAT)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= IDX_W'(NCH - 1);
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            busy_q     <= (state_d == BURST);
            err_ovf_q  <= err_ovf_q | fifo_overflow;
        end
    end

    assign owner   = owner_q;
    assign busy    = busy_q;
    assign err_ovf = err_ovf_q;

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Directed self-checking bench for fifo_rr_wr_arbiter; inputs change on the falling edge.
module tb_fifo_rr_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  gnt;
    logic        fifo_wr_en;
    logic [7:0]  fifo_buf_in;
    logic        fifo_buf_full;
    logic        fifo_threshold;
    logic        fifo_overflow;
    logic [1:0]  owner;
    logic        busy;
    logic        err_ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fifo_rr_wr_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_data       (req_data),
        .req_last       (req_last),
        .gnt            (gnt),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_buf_in    (fifo_buf_in),
        .fifo_buf_full  (fifo_buf_full),
        .fifo_threshold (fifo_threshold),
        .fifo_overflow  (fifo_overflow),
        .owner          (owner),
        .busy           (busy),
        .err_ovf        (err_ovf)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_data(input int ch, input logic [7:0] v);
        req_data[ch*8 +: 8] = v;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; req_data = '0; req_last = '0;
        fifo_buf_full = 1'b0; fifo_threshold = 1'b0; fifo_overflow = 1'b0;
        tick(); tick(); #1;
        total_cnt++; if (owner !== 2'd3) $display("FAIL reset_owner: got %0d want 3", owner); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if (err_ovf !== 1'b0) $display("FAIL reset_err: got %0b want 0", err_ovf); else pass_cnt++;
        total_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", gnt); else pass_cnt++;
        total_cnt++; if (fifo_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %0b want 0", fifo_wr_en); else pass_cnt++;
        total_cnt++; if (fifo_buf_in !== 8'h00) $display("FAIL reset_buf_in: got %02h want 00", fifo_buf_in); else pass_cnt++;
    endtask

    task automatic test_single;
        tick(); rst = 1'b0; req = 4'b0001; set_data(0, 8'hA0); #1;
        total_cnt++; if (fifo_wr_en !== 1'b0) $display("FAIL single_bubble_wr: got %0b want 0", fifo_wr_en); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL single_bubble_busy: got %0b want 0", busy); else pass_cnt++;
        tick(); #1;
        total_cnt++; if (busy !== 1'b1) $display("FAIL single_busy: got %0b want 1", busy); else pass_cnt++;
        total_cnt++; if (owner !== 2'd0) $display("FAIL single_owner: got %0d want 0", owner); else pass_cnt++;
        total_cnt++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", gnt); else pass_cnt++;
        total_cnt++; if (fifo_buf_in !== 8'hA0) $display("FAIL single_d0: got %02h want A0", fifo_buf_in); else pass_cnt++;
        $display("single wr ch0 data=%02h", fifo_buf_in);
        tick(); set_data(0, 8'hA1); #1;
        total_cnt++; if (fifo_wr_en !== 1'b1 || fifo_buf_in !== 8'hA1) $display("FAIL single_d1: got wr=%0b %02h want 1 A1", fifo_wr_en, fifo_buf_in); else pass_cnt++;
        $display("single wr ch0 data=%02h", fifo_buf_in);
        tick(); set_data(0, 8'hA2); req_last = 4'b0001; #1;
        total_cnt++; if (fifo_wr_en !== 1'b1 || fifo_buf_in !== 8'hA2) $display("FAIL single_d2: got wr=%0b %02h want 1 A2", fifo_wr_en, fifo_buf_in); else pass_cnt++;
        $display("single wr ch0 data=%02h", fifo_buf_in);
        tick(); req = 4'b0000; req_last = 4'b0000; #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL single_end_busy: got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if (owner !== 2'd0) $display("FAIL single_end_owner: got %0d want 0", owner); else pass_cnt++;
        total_cnt++; if (fifo_wr_en !== 1'b0) $display("FAIL single_end_wr: got %0b want 0", fifo_wr_en); else pass_cnt++;
    endtask

    task automatic test_rotate;
        int cnt[4];
        int nwr;
        int ech;
        cnt = '{0, 0, 0, 0};
        nwr = 0;
        tick(); rst = 1'b1;
        for (int t = 0; t < 36; t++) begin
            tick(); rst = 1'b0; req = 4'b1111;
            for (int ch = 0; ch < 4; ch++) set_data(ch, 8'(ch*16 + cnt[ch]));
            #1;
            if (fifo_wr_en === 1'b1) begin
                ech = (nwr / 8) % 4;
                total_cnt++; if (gnt !== 4'(1 << ech)) $display("FAIL rotate_gnt[%0d]: got %b want ch%0d", nwr, gnt, ech); else pass_cnt++;
                total_cnt++; if (fifo_buf_in !== 8'(ech*16 + cnt[ech])) $display("FAIL rotate_data[%0d]: got %02h want %02h", nwr, fifo_buf_in, 8'(ech*16 + cnt[ech])); else pass_cnt++;
                $display("rotate wr gnt=%b data=%02h", gnt, fifo_buf_in);
                cnt[ech]++;
                nwr++;
            end
        end
        total_cnt++; if (nwr !== 32) $display("FAIL rotate_count: got %0d want 32", nwr); else pass_cnt++;
        tick(); req = 4'b0000; #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rotate_end_busy: got %0b want 0", busy); else pass_cnt++;
        total_cnt++; if (owner !== 2'd3) $display("FAIL rotate_end_owner: got %0d want 3", owner); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        int cnt2;
        logic exp_wr;
        cnt2 = 0;
        for (int t = 0; t < 14; t++) begin
            tick(); req = 4'b0100; fifo_buf_full = (t >= 3 && t <= 7);
            set_data(2, 8'(8'hC0 + cnt2)); #1;
            exp_wr = (t >= 1) && !fifo_buf_full && (cnt2 < 8);
            total_cnt++; if (fifo_wr_en !== exp_wr) $display("FAIL bp_wr_en[t%0d]: got %0b want %0b", t, fifo_wr_en, exp_wr); else pass_cnt++;
            if (fifo_buf_full) begin
                total_cnt++; if (gnt !== 4'b0000 || busy !== 1'b1) $display("FAIL bp_stall[t%0d]: got gnt=%b busy=%0b want 0000 1", t, gnt, busy); else pass_cnt++;
            end
            if (exp_wr) begin
                total_cnt++; if (fifo_buf_in !== 8'(8'hC0 + cnt2)) $display("FAIL bp_data[t%0d]: got %02h want %02h", t, fifo_buf_in, 8'(8'hC0 + cnt2)); else pass_cnt++;
                $display("bp wr ch2 data=%02h", fifo_buf_in);
                cnt2++;
            end
        end
        tick(); req = 4'b0000; fifo_buf_full = 1'b0; #1;
        total_cnt++; if (busy !== 1'b0 || owner !== 2'd2) $display("FAIL bp_end: got busy=%0b owner=%0d want 0 2", busy, owner); else pass_cnt++;
    endtask

    task automatic test_threshold;
        for (int t = 0; t < 3; t++) begin
            tick(); fifo_threshold = 1'b1; req = 4'b1110; #1;
            total_cnt++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) $display("FAIL thr_hold[%0d]: got busy=%0b wr=%0b want 0 0", t, busy, fifo_wr_en); else pass_cnt++;
        end
        tick(); req = 4'b1111; set_data(0, 8'h50); req_last = 4'b0001; #1;
        total_cnt++; if (fifo_wr_en !== 1'b0) $display("FAIL thr_bubble: got %0b want 0", fifo_wr_en); else pass_cnt++;
        tick(); #1;
        total_cnt++; if (owner !== 2'd0 || gnt !== 4'b0001 || fifo_buf_in !== 8'h50) $display("FAIL thr_ch0: got owner=%0d gnt=%b data=%02h want 0 0001 50", owner, gnt, fifo_buf_in); else pass_cnt++;
        $display("thr wr gnt=%b data=%02h", gnt, fifo_buf_in);
        tick(); fifo_threshold = 1'b0; req = 4'b1110; req_last = 4'b0010; set_data(1, 8'h61); #1;
        total_cnt++; if (busy !== 1'b0 || fifo_wr_en !== 1'b0) $display("FAIL thr_idle: got busy=%0b wr=%0b want 0 0", busy, fifo_wr_en); else pass_cnt++;
        tick(); #1;
        total_cnt++; if (owner !== 2'd1 || gnt !== 4'b0010 || fifo_buf_in !== 8'h61) $display("FAIL thr_ch1: got owner=%0d gnt=%b data=%02h want 1 0010 61", owner, gnt, fifo_buf_in); else pass_cnt++;
        $display("thr wr gnt=%b data=%02h", gnt, fifo_buf_in);
        tick(); req = 4'b0000; req_last = 4'b0000; #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL thr_end_busy: got %0b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_withdraw;
        tick(); req = 4'b1001; req_last = 4'b0000; set_data(3, 8'hD0); set_data(0, 8'h0A); #1;
        total_cnt++; if (fifo_wr_en !== 1'b0) $display("FAIL wd_bubble: got %0b want 0", fifo_wr_en); else pass_cnt++;
        tick(); #1;
        total_cnt++; if (owner !== 2'd3 || gnt !== 4'b1000 || fifo_buf_in !== 8'hD0) $display("FAIL wd_b0: got owner=%0d gnt=%b data=%02h want 3 1000 D0", owner, gnt, fifo_buf_in); else pass_cnt++;
        $display("wd wr gnt=%b data=%02h", gnt, fifo_buf_in);
        tick(); set_data(3, 8'hD1); #1;
        total_cnt++; if (gnt !== 4'b1000 || fifo_buf_in !== 8'hD1) $display("FAIL wd_b1: got gnt=%b data=%02h want 1000 D1", gnt, fifo_buf_in); else pass_cnt++;
        $display("wd wr gnt=%b data=%02h", gnt, fifo_buf_in);
        tick(); req = 4'b0001; #1;
        total_cnt++; if (fifo_wr_en !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1) $display("FAIL wd_drop: got wr=%0b gnt=%b busy=%0b want 0 0000 1", fifo_wr_en, gnt, busy); else pass_cnt++;
        tick(); #1;
        total_cnt++; if (busy !== 1'b0 || owner !== 2'd3 || fifo_wr_en !== 1'b0) $display("FAIL wd_idle: got busy=%0b owner=%0d wr=%0b want 0 3 0", busy, owner, fifo_wr_en); else pass_cnt++;
        tick(); req_last = 4'b0001; #1;
        total_cnt++; if (owner !== 2'd0 || gnt !== 4'b0001 || fifo_buf_in !== 8'h0A) $display("FAIL wd_next: got owner=%0d gnt=%b data=%02h want 0 0001 0A", owner, gnt, fifo_buf_in); else pass_cnt++;
        $display("wd wr gnt=%b data=%02h", gnt, fifo_buf_in);
        tick(); req = 4'b0000; req_last = 4'b0000; #1;
    endtask

    task automatic test_reset_mid;
        tick(); fifo_overflow = 1'b1; #1;
        tick(); fifo_overflow = 1'b0; #1;
        total_cnt++; if (err_ovf !== 1'b1) $display("FAIL ovf_set: got %0b want 1", err_ovf); else pass_cnt++;
        tick(); req = 4'b0010; set_data(1, 8'hB0); #1;
        total_cnt++; if (fifo_wr_en !== 1'b0) $display("FAIL rm_bubble: got %0b want 0", fifo_wr_en); else pass_cnt++;
        for (int b = 0; b < 4; b++) begin
            tick(); set_data(1, 8'(8'hB0 + b)); #1;
            total_cnt++; if (fifo_wr_en !== 1'b1 || fifo_buf_in !== 8'(8'hB0 + b)) $display("FAIL rm_beat[%0d]: got wr=%0b data=%02h want 1 %02h", b, fifo_wr_en, fifo_buf_in, 8'(8'hB0 + b)); else pass_cnt++;
            $display("rm wr ch1 data=%02h", fifo_buf_in);
        end
        total_cnt++; if (err_ovf !== 1'b1) $display("FAIL ovf_sticky: got %0b want 1", err_ovf); else pass_cnt++;
        tick(); rst = 1'b1; set_data(1, 8'hB4); #1;
        tick(); rst = 1'b0; req = 4'b0011; set_data(0, 8'hE0); #1;
        total_cnt++; if (fifo_wr_en !== 1'b0) $display("FAIL rm_post_wr: got %0b want 0", fifo_wr_en); else pass_cnt++;
        total_cnt++; if (owner !== 2'd3 || busy !== 1'b0) $display("FAIL rm_post_state: got owner=%0d busy=%0b want 3 0", owner, busy); else pass_cnt++;
        total_cnt++; if (err_ovf !== 1'b0) $display("FAIL ovf_clear: got %0b want 0", err_ovf); else pass_cnt++;
        tick(); req_last = 4'b0001; #1;
        total_cnt++; if (owner !== 2'd0 || gnt !== 4'b0001 || fifo_buf_in !== 8'hE0) $display("FAIL rm_first_grant: got owner=%0d gnt=%b data=%02h want 0 0001 E0", owner, gnt, fifo_buf_in); else pass_cnt++;
        $display("rm wr gnt=%b data=%02h", gnt, fifo_buf_in);
        tick(); req = 4'b0000; req_last = 4'b0000; #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_backpressure();
        test_threshold();
        test_withdraw();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fifo_rr_wr_arbiter.md
Name: fifo_rr_wr_arbiter

Overview:
- Round-robin write arbiter that lets 4 producer channels share one 64-deep × 8-bit single-clock FIFO write port.
- Grants one channel at a time for a bounded burst, drives the FIFO's wr_en/buf_in and honours buf_full backpressure.
- Throttles low-priority channels once the FIFO reaches its half-full threshold.
- Sits directly in front of the FIFO's write side.

Parameters:
- NCH, 4, number of producer channels (fixed 4 in this revision; index width 2).
- DW, 8, data width; matches FIFO buf_in.
- MAX_BURST, 8, maximum beats per grant (range 1..16).
- HIPRI_MASK, 4'b0001, channels still eligible while fifo_threshold=1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NCH  per-channel request / beat valid.
- req_data  in  NCH*DW  packed data; channel i at [i*DW +: DW].
- req_last  in  NCH  marks final beat of channel i's packet.
- gnt  out  NCH  per-channel beat accept (combinational).
- fifo_wr_en  out  1  FIFO write enable (combinational).
- fifo_buf_in  out  DW  FIFO write data (combinational mux).
- fifo_buf_full  in  1  FIFO full flag.
- fifo_threshold  in  1  FIFO count >= 32.
- fifo_overflow  in  1  FIFO overflow flag.
- owner  out  2  registered current/last owner index.
- busy  out  1  registered; 1 while in BURST.
- err_ovf  out  1  sticky overflow error.

Behaviour:
- Reset, synchronous on the clk edge with rst=1:
  - state=IDLE, owner=NCH-1 so channel 0 wins first, beat_cnt=0, busy=0, err_ovf=0.
  - gnt=0, fifo_wr_en=0, fifo_buf_in=0.
  - Reset mid-burst aborts the burst with no further writes. Producers must treat a burst without a last beat as aborted.
- FSM states: IDLE, BURST.
- IDLE:
  - Eligible set E = req, masked with HIPRI_MASK when fifo_threshold=1.
  - If E≠0, pick the first set bit searching (owner+1) mod NCH upward with wrap. Register owner, set beat_cnt=0, then go to BURST.
  - Arbitration costs one bubble cycle. No gnt is asserted in IDLE.
- BURST:
  - gnt[owner] = req[owner] & ~fifo_buf_full. All other gnt bits are 0.
  - fifo_wr_en = |gnt; fifo_buf_in = req_data[owner]. When fifo_wr_en=0, fifo_buf_in = 0.
  - On an accepted beat, beat_cnt increments.
  - Exit to IDLE after an accepted beat with req_last[owner]=1, or after an accepted beat where beat_cnt == MAX_BURST-1.
  - Exit to IDLE if req[owner]=0 in any BURST cycle (producer withdrew); no write occurs that cycle.
  - When fifo_buf_full=1, stay in BURST. No beat is accepted, beat_cnt holds, and there is no timeout.
- Threshold is sampled only in IDLE. A granted burst completes even if the threshold rises mid-burst.
- Fairness: owner is retained after exit and is the round-robin pivot. A channel cannot win two consecutive grants while another eligible channel is requesting.
- Producer rule: req_data and req_last stay stable while req=1 and gnt=0.
- err_ovf is set when fifo_overflow=1 on any clock and clears only on rst. Given the gating, it must never assert in normal operation.
- busy = (state==BURST), registered.
- Throughput: at most MAX_BURST beats per MAX_BURST+1 cycles per grant.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, BURST).
  - Constants NCH, DW, FIFO_DEPTH=64, FIFO_THRESH=32.
  - Channel index width.
- One sub-module is natural: rr_pick. It is a combinational round-robin priority selector (inputs: eligible mask, pivot; outputs: index, valid) and is reusable by a future read-side scheduler.

Test Plan:
- Reset then req=4'b0001, data 0xA0..0xA2, last on the 3rd beat: owner=0, busy rises 1 cycle later, 3 wr_en pulses write A0,A1,A2, then back to IDLE.
- req=4'b1111 held, no last, MAX_BURST=8: grants rotate 0,1,2,3,0. Each burst is exactly 8 writes with a 1-cycle gap, so 36 cycles yield 32 writes.
- Ch2 bursting and fifo_buf_full forced high for 5 cycles mid-burst: gnt=0 and wr_en=0 for those 5 cycles, beat_cnt frozen, burst resumes, no data lost or duplicated.
- fifo_threshold=1, req=4'b1110: stays IDLE with no grants. Raising req[0] grants ch0. Dropping threshold then grants ch1.
- Ch3 withdraws req after 2 of 8 beats: exactly 2 writes, IDLE next cycle, next grant goes to ch0 if requesting.
- rst pulsed during a ch1 burst at beat 4: wr_en=0 next cycle, owner=3, busy=0, and the first post-reset grant goes to ch0. Also assert fifo_overflow for 1 cycle: err_ovf stays 1 until rst.
